// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// | riscv_pkg                                                                |
// | Shared RV32 definitions: load funct3 codes and the WB register bundle.   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic [XLEN-1:0] data;
    logic            exc;
  } wb_bundle_t;

endpackage

`default_nettype wire

// File: rtl/load_formatter.sv
// ---------------------------------------------------------------------------
// | load_formatter                                                           |
// | Size/sign formatting of the raw load word plus alignment check.          |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module load_formatter
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result,
  output logic            misalign
);

  // The memory returns bytes starting at the effective address, so the
  // selected data always sits in the low lanes regardless of addr_lo.
  always_comb begin
    result = raw;
    unique case (funct3)
      F3_LB:   result = {{(XLEN-8){raw[7]}}, raw[7:0]};
      F3_LH:   result = {{(XLEN-16){raw[15]}}, raw[15:0]};
      F3_LW:   result = raw;
      F3_LBU:  result = {{(XLEN-8){1'b0}}, raw[7:0]};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: result = raw;
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    unique case (funct3)
      F3_LH, F3_LHU: misalign = addr_lo[0];
      F3_LW:         misalign = (addr_lo != 2'b00);
      default:       misalign = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// | mem_wb_stage                                                             |
// | MEM/WB pipeline register: load formatting, WB mux, stall/flush, retire   |
// | counter. Optional macro MEM_MISALIGN_TRAP_EN enables misaligned traps.   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_mem_data,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [2:0]       in_funct3,
  output logic             wb_valid,
  output logic [XLEN-1:0]  wb_pc,
  output logic [4:0]       wb_rd,
  output logic             wb_reg_write,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_exc,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [XLEN-1:0] load_data;
  logic            misalign;
  logic            exc;
  wb_bundle_t      next_wb;
  wb_bundle_t      wb_q;
  logic [CNT_W-1:0] cnt_q;

  load_formatter #(
    .XLEN (XLEN)
  ) u_load_formatter (
    .funct3   (in_funct3),
    .addr_lo  (in_alu_result[1:0]),
    .raw      (in_mem_data),
    .result   (load_data),
    .misalign (misalign)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign exc = in_valid & in_mem_to_reg & misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign exc = 1'b0;
`endif

  always_comb begin
    next_wb           = '0;
    next_wb.valid     = in_valid;
    next_wb.pc        = in_pc;
    next_wb.rd        = in_rd;
    next_wb.reg_write = in_valid & in_reg_write & (in_rd != 5'd0) & ~exc;
    next_wb.data      = in_mem_to_reg ? load_data : in_alu_result;
    next_wb.exc       = exc;
  end

  // The counter looks at what is currently in WB: an instruction is retired
  // on the edge where it leaves the stage, so a stalled one counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wb_q.valid && !wb_q.exc && !stall) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        wb_q <= '0;
      end else if (!stall) begin
        wb_q <= next_wb;
      end
    end
  end

  assign wb_valid     = wb_q.valid;
  assign wb_pc        = wb_q.pc;
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_data      = wb_q.data;
  assign wb_exc       = wb_q.exc;
  assign retire_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// | tb_mem_wb_stage                                                          |
// | Directed + random checks of mem_wb_stage against a behavioural model.   |
// | Revision: 1.0                                                            |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_mem_data = '0;
  logic [4:0]  in_rd = '0;
  logic        in_reg_write = 1'b0;
  logic        in_mem_to_reg = 1'b0;
  logic [2:0]  in_funct3 = '0;

  logic        wb_valid, wb_reg_write, wb_exc;
  logic [31:0] wb_pc, wb_data, retire_cnt;
  logic [4:0]  wb_rd;

  logic        s_valid, s_reg_write, s_exc;
  logic [31:0] s_pc, s_data;
  logic [4:0]  s_rd;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_funct3(in_funct3),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_exc(wb_exc),
    .retire_cnt(retire_cnt)
  );

  mem_wb_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_to_reg(in_mem_to_reg), .in_funct3(in_funct3),
    .wb_valid(s_valid), .wb_pc(s_pc), .wb_rd(s_rd),
    .wb_reg_write(s_reg_write), .wb_data(s_data), .wb_exc(s_exc),
    .retire_cnt(s_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state of the WB stage
  bit          m_valid, m_we, m_exc;
  logic [31:0] m_pc, m_data;
  logic [4:0]  m_rd;
  int unsigned m_cnt;

  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = d % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = d % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd4: v = d % 256;
      3'd5: v = d % 65536;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic bit misal(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd1 || f3 == 3'd5) return (a % 2) != 0;
    if (f3 == 3'd2)               return (a % 4) != 0;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input bit v, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [4:0] rd, input bit rw,
                           input bit m2r, input logic [2:0] f3);
    in_valid = v; in_pc = pc; in_alu_result = alu; in_mem_data = mem;
    in_rd = rd; in_reg_write = rw; in_mem_to_reg = m2r; in_funct3 = f3;
  endtask

  task automatic bubble();
    set_instr(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic rand_instr();
    set_instr(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
              1'($urandom), 1'($urandom), 3'($urandom));
  endtask

  // Advance the model for the coming edge, clock it, then compare everything.
  task automatic tick();
    bit ex;
    ex = TRAP && in_valid && in_mem_to_reg && misal(in_funct3, in_alu_result);
    if (reset) begin
      m_valid = 0; m_pc = 0; m_rd = 0; m_we = 0; m_data = 0; m_exc = 0; m_cnt = 0;
    end else begin
      if (m_valid && !m_exc && !stall) m_cnt = m_cnt + 1;
      if (flush) begin
        m_valid = 0; m_pc = 0; m_rd = 0; m_we = 0; m_data = 0; m_exc = 0;
      end else if (!stall) begin
        m_valid = in_valid;
        m_pc    = in_pc;
        m_rd    = in_rd;
        m_we    = in_valid && in_reg_write && (in_rd != 0) && !ex;
        m_data  = in_mem_to_reg ? fmt(in_funct3, in_mem_data) : in_alu_result;
        m_exc   = ex;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_valid", 32'(wb_valid), 32'(m_valid));
    chk("wb_pc", wb_pc, m_pc);
    chk("wb_rd", 32'(wb_rd), 32'(m_rd));
    chk("wb_reg_write", 32'(wb_reg_write), 32'(m_we));
    chk("wb_data", wb_data, m_data);
    chk("wb_exc", 32'(wb_exc), 32'(m_exc));
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("retire_cnt4", 32'(s_cnt), m_cnt % 16);
    chk("wb_data4", s_data, m_data);
  endtask

  int unsigned c0;

  initial begin
    // Reset held two cycles with random inputs
    reset = 1'b1;
    rand_instr(); stall = 1'($urandom); flush = 1'($urandom);
    tick();
    rand_instr();
    tick();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_cnt", retire_cnt, 32'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    // Load formatting of 0x0000_80F0
    set_instr(1, 32'h100, 32'h1000, 32'h0000_80F0, 5'd5, 1, 1, 3'd0); tick();
    chk("LB", wb_data, 32'hFFFF_FFF0);
    set_instr(1, 32'h104, 32'h1000, 32'h0000_80F0, 5'd5, 1, 1, 3'd4); tick();
    chk("LBU", wb_data, 32'h0000_00F0);
    set_instr(1, 32'h108, 32'h1000, 32'h0000_80F0, 5'd5, 1, 1, 3'd1); tick();
    chk("LH", wb_data, 32'hFFFF_80F0);
    set_instr(1, 32'h10C, 32'h1000, 32'h0000_80F0, 5'd5, 1, 1, 3'd5); tick();
    chk("LHU", wb_data, 32'h0000_80F0);
    chk("LHU_we", 32'(wb_reg_write), 32'd1);

    // ALU result to x0 is never written
    set_instr(1, 32'h110, 32'h1234, 32'hDEAD_BEEF, 5'd0, 1, 0, 3'd2); tick();
    chk("x0_data", wb_data, 32'h1234);
    chk("x0_we", 32'(wb_reg_write), 32'd0);
    chk("x0_valid", 32'(wb_valid), 32'd1);

    // Stall for three cycles: frozen, counted once
    set_instr(1, 32'h200, 32'hAAAA, 32'h0, 5'd7, 1, 0, 3'd0); tick();
    c0 = m_cnt;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr(); tick();
      chk("stall_data", wb_data, 32'hAAAA);
    end
    stall = 1'b0; bubble(); tick();
    chk("stall_cnt", retire_cnt, c0 + 1);

    // Flush beats stall
    set_instr(1, 32'h300, 32'h55, 32'h0, 5'd9, 1, 0, 3'd0); tick();
    stall = 1'b1; flush = 1'b1; rand_instr(); tick();
    chk("flush_stall_valid", 32'(wb_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;

    // Reset mid-stall presents a bubble
    set_instr(1, 32'h400, 32'h77, 32'h0, 5'd3, 1, 0, 3'd0); tick();
    stall = 1'b1; reset = 1'b1; rand_instr(); tick();
    chk("rst_stall_valid", 32'(wb_valid), 32'd0);
    stall = 1'b0; reset = 1'b0;

    // 17 back-to-back instructions wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      set_instr(1, 32'(i * 4), $urandom, $urandom, 5'd1 + 5'(i % 30), 1, 0, 3'd0);
      tick();
    end
    bubble(); tick();
    chk("wrap4", 32'(s_cnt), 32'd1);
    chk("wrap32", retire_cnt, 32'd17);

    // Misaligned LW at address 2
    bubble(); tick();
    c0 = m_cnt;
    set_instr(1, 32'h500, 32'h2, 32'hCAFE_F00D, 5'd4, 1, 1, 3'd2); tick();
    chk("mis_exc", 32'(wb_exc), TRAP ? 32'd1 : 32'd0);
    chk("mis_we", 32'(wb_reg_write), TRAP ? 32'd0 : 32'd1);
    chk("mis_valid", 32'(wb_valid), 32'd1);
    bubble(); tick();
    chk("mis_cnt", retire_cnt, TRAP ? c0 : c0 + 1);

    // Random traffic with occasional stall/flush/reset
    for (int i = 0; i < 200; i++) begin
      rand_instr();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0; stall = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
